// File: rtl/axis_fifo_streamer_pt.sv
// AXI-Stream FIFO streamer with packet-boundary-safe PASS/DRAIN/HOLD mode control
// and occupancy / packet / drop counters for the reconfiguration sequencer.
`timescale 1ns/1ps
module axis_fifo_streamer_pt #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [1:0]              mode,
   input  logic [DATA_WIDTH-1:0]   S_AXI_TDATA,
   input  logic [DATA_WIDTH/8-1:0] S_AXI_TKEEP,
   input  logic                    S_AXI_TVALID,
   output logic                    S_AXI_TREADY,
   input  logic                    S_AXI_TLAST,
   output logic [DATA_WIDTH-1:0]   M_AXI_TDATA,
   output logic [DATA_WIDTH/8-1:0] M_AXI_TKEEP,
   output logic                    M_AXI_TVALID,
   input  logic                    M_AXI_TREADY,
   output logic                    M_AXI_TLAST,
   output logic [1:0]              cur_mode,
   output logic [DEPTH_LOG2:0]     level,
   output logic [CNT_WIDTH-1:0]    pkt_cnt,
   output logic [CNT_WIDTH-1:0]    drop_cnt
);

   localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned WORD_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1;
   localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {
      MODE_PASS  = 2'b00,
      MODE_DRAIN = 2'b01,
      MODE_HOLD  = 2'b10
   } mode_t;

   typedef logic [DEPTH_LOG2:0]   ptr_t;
   typedef logic [DEPTH_LOG2-1:0] idx_t;

   mode_t                 state;
   logic                  in_pkt;
   ptr_t                  wr_ptr;
   ptr_t                  rd_ptr;
   ptr_t                  wr_nxt;
   ptr_t                  rd_nxt;
   logic [WORD_WIDTH-1:0] mem [DEPTH];
   logic [WORD_WIDTH-1:0] s_word;
   logic [WORD_WIDTH-1:0] head_nxt;
   logic                  full;
   logic                  empty_nxt;
   logic                  accept;
   logic                  push;
   logic                  drop;
   logic                  pop;
   logic                  mode_update;

   function automatic mode_t decode_mode(input logic [1:0] m);
      case (m)
         2'b00:   return MODE_PASS;
         2'b01:   return MODE_DRAIN;
         default: return MODE_HOLD;
      endcase
   endfunction

   assign full = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

   always_comb begin
      S_AXI_TREADY = 1'b0;
      case (state)
         MODE_PASS:  S_AXI_TREADY = !full;
         MODE_DRAIN: S_AXI_TREADY = 1'b1;
         default:    S_AXI_TREADY = 1'b0;
      endcase
   end

   assign accept = S_AXI_TVALID && S_AXI_TREADY;
   assign push   = accept && (state == MODE_PASS);
   assign drop   = accept && (state == MODE_DRAIN);
   assign pop    = M_AXI_TVALID && M_AXI_TREADY;

   assign wr_nxt    = wr_ptr + ptr_t'(push);
   assign rd_nxt    = rd_ptr + ptr_t'(pop);
   assign empty_nxt = (wr_nxt == rd_nxt);
   assign s_word    = {S_AXI_TDATA, S_AXI_TKEEP, S_AXI_TLAST};

   // The output registers mirror the post-edge head; a push landing in the head
   // slot (FIFO empty after this edge's pop) is forwarded so latency stays 1 cycle.
   always_comb begin
      head_nxt = mem[idx_t'(rd_nxt)];
      if (push && (idx_t'(wr_ptr) == idx_t'(rd_nxt)))
         head_nxt = s_word;
   end

   assign mode_update = accept ? S_AXI_TLAST : !in_pkt;

   always_ff @(posedge clk) begin
      if (push)
         mem[idx_t'(wr_ptr)] <= s_word;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= MODE_PASS;
         in_pkt       <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         M_AXI_TVALID <= 1'b0;
         M_AXI_TDATA  <= '0;
         M_AXI_TKEEP  <= '0;
         M_AXI_TLAST  <= 1'b0;
         pkt_cnt      <= '0;
         drop_cnt     <= '0;
      end else begin
         wr_ptr       <= wr_nxt;
         rd_ptr       <= rd_nxt;
         M_AXI_TVALID <= !empty_nxt;
         {M_AXI_TDATA, M_AXI_TKEEP, M_AXI_TLAST} <= head_nxt;
         if (accept)
            in_pkt <= !S_AXI_TLAST;
         if (mode_update)
            state <= decode_mode(mode);
         if (pop && M_AXI_TLAST)
            pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
         if (drop)
            drop_cnt <= drop_cnt + CNT_WIDTH'(1);
      end
   end

   assign cur_mode = state;
   assign level    = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_axis_fifo_streamer_pt.sv
// Scoreboard bench for axis_fifo_streamer_pt: directed stimulus queues expected
// beats, a negedge monitor pops and compares every M-side handshake.
`timescale 1ns/1ps
module tb_axis_fifo_streamer_pt;
   localparam int DW = 32;
   localparam int DL = 4;
   localparam int CW = 32;
   localparam int KW = DW / 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic [DW-1:0] s_tdata = '0;
   logic [KW-1:0] s_tkeep = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tready;
   logic          s_tlast = 1'b0;
   logic [DW-1:0] m_tdata;
   logic [KW-1:0] m_tkeep;
   logic          m_tvalid;
   logic          m_tready = 1'b0;
   logic          m_tlast;
   logic [1:0]    cur_mode;
   logic [DL:0]   level;
   logic [CW-1:0] pkt_cnt;
   logic [CW-1:0] drop_cnt;

   int checks = 0;
   int failures = 0;
   bit rand_rdy = 0;
   logic [DW+KW:0] exp_q[$];

   axis_fifo_streamer_pt #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .mode(mode),
      .S_AXI_TDATA(s_tdata), .S_AXI_TKEEP(s_tkeep), .S_AXI_TVALID(s_tvalid),
      .S_AXI_TREADY(s_tready), .S_AXI_TLAST(s_tlast),
      .M_AXI_TDATA(m_tdata), .M_AXI_TKEEP(m_tkeep), .M_AXI_TVALID(m_tvalid),
      .M_AXI_TREADY(m_tready), .M_AXI_TLAST(m_tlast),
      .cur_mode(cur_mode), .level(level), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset && m_tvalid && m_tready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat: got 0x%0h expected none", {m_tdata, m_tkeep, m_tlast});
         end else begin
            check("m_beat", 64'({m_tdata, m_tkeep, m_tlast}), 64'(exp_q.pop_front()));
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input bit store);
      int n;
      n = 0;
      s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
      forever begin
         @(negedge clk);
         if (s_tready) break;
         n++;
         if (n > 300) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got tready=0 expected accept of 0x%0h", d);
            s_tvalid = 1'b0;
            return;
         end
      end
      @(posedge clk); #1;
      s_tvalid = 1'b0;
      if (store) exp_q.push_back({d, k, l});
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_drained(input string name);
      for (int i = 0; i < 500; i++) begin
         if (level == 0 && exp_q.size() == 0 && !m_tvalid) break;
         cycles(1);
      end
      check({name, "_level"}, 64'(level), 64'd0);
      check({name, "_queue"}, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      // Reset state
      cycles(2);
      check("rst_valid", 64'(m_tvalid), 64'd0);
      check("rst_level", 64'(level), 64'd0);
      @(negedge clk); reset = 1'b1;
      cycles(1);
      check("rst_mode", 64'(cur_mode), 64'd0);
      check("rst_cnts", 64'({pkt_cnt, drop_cnt}), 64'd0);
      check("rst_tready", 64'(s_tready), 64'd1);

      // Basic pass
      m_tready = 1'b1;
      send(32'h11, 4'hF, 1'b0, 1'b1);
      check("latency_valid", 64'(m_tvalid), 64'd1);
      send(32'h22, 4'hF, 1'b0, 1'b1);
      send(32'h33, 4'hF, 1'b0, 1'b1);
      send(32'h44, 4'hF, 1'b1, 1'b1);
      wait_drained("basic");
      check("basic_pkt", 64'(pkt_cnt), 64'd1);

      // Backpressure / full
      m_tready = 1'b0;
      for (int i = 0; i < 16; i++)
         send(32'h100 + 32'(i), 4'hF, 1'(i == 15), 1'b1);
      check("full_level", 64'(level), 64'd16);
      check("full_tready", 64'(s_tready), 64'd0);
      s_tdata = 32'hDEAD; s_tkeep = 4'hF; s_tlast = 1'b0; s_tvalid = 1'b1;
      repeat (3) @(negedge clk);
      check("full_hold_tready", 64'(s_tready), 64'd0);
      check("full_hold_level", 64'(level), 64'd16);
      check("full_hold_data", 64'({m_tvalid, m_tdata, m_tlast}), 64'({1'b1, 32'h100, 1'b0}));
      @(posedge clk); #1;
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      wait_drained("full");
      check("full_pkt", 64'(pkt_cnt), 64'd2);

      // Mid-packet mode change
      send(32'hA1, 4'hF, 1'b0, 1'b1);
      send(32'hA2, 4'hF, 1'b0, 1'b1);
      mode = 2'b01;
      send(32'hA3, 4'h3, 1'b0, 1'b1);
      check("mid_mode_b3", 64'(cur_mode), 64'd0);
      send(32'hA4, 4'hF, 1'b0, 1'b1);
      send(32'hA5, 4'hF, 1'b0, 1'b1);
      check("mid_mode_b5", 64'(cur_mode), 64'd0);
      send(32'hA6, 4'h1, 1'b1, 1'b1);
      check("mid_mode_b6", 64'(cur_mode), 64'd1);
      send(32'hD1, 4'hF, 1'b0, 1'b0);
      send(32'hD2, 4'hF, 1'b0, 1'b0);
      send(32'hD3, 4'hF, 1'b1, 1'b0);
      wait_drained("drain");
      check("drain_cnt", 64'(drop_cnt), 64'd3);
      check("drain_pkt", 64'(pkt_cnt), 64'd3);

      // HOLD drains output
      mode = 2'b00;
      cycles(2);
      check("back_to_pass", 64'(cur_mode), 64'd0);
      m_tready = 1'b0;
      for (int i = 0; i < 5; i++)
         send(32'hB0 + 32'(i), 4'hF, 1'(i == 4), 1'b1);
      mode = 2'b10;
      cycles(2);
      check("hold_mode", 64'(cur_mode), 64'd2);
      check("hold_tready", 64'(s_tready), 64'd0);
      check("hold_level", 64'(level), 64'd5);
      m_tready = 1'b1;
      wait_drained("hold");
      check("hold_pkt", 64'(pkt_cnt), 64'd4);
      mode = 2'b00;
      cycles(1);
      check("hold_exit_tready", 64'(s_tready), 64'd1);

      // Reset mid-operation
      m_tready = 1'b0;
      for (int i = 0; i < 7; i++)
         send(32'hC0 + 32'(i), 4'hF, 1'b0, 1'b1);
      check("pre_rst_level", 64'(level), 64'd7);
      check("pre_rst_valid", 64'(m_tvalid), 64'd1);
      #3 reset = 1'b0;
      #1;
      exp_q.delete();
      check("async_rst_valid", 64'(m_tvalid), 64'd0);
      check("async_rst_level", 64'(level), 64'd0);
      check("async_rst_cnts", 64'({pkt_cnt, drop_cnt}), 64'd0);
      check("async_rst_mode", 64'(cur_mode), 64'd0);
      #2 reset = 1'b1;
      cycles(1);
      m_tready = 1'b1;
      send(32'hABC, 4'h7, 1'b1, 1'b1);
      check("post_rst_valid", 64'(m_tvalid), 64'd1);
      wait_drained("post_rst");
      check("post_rst_pkt", 64'(pkt_cnt), 64'd1);

      // Pointer wrap with random backpressure
      rand_rdy = 1;
      for (int i = 0; i < 3 * 16 + 5; i++)
         send($urandom, 4'($urandom_range(0, 15)), 1'((i % 7) == 6), 1'b1);
      rand_rdy = 0;
      m_tready = 1'b1;
      cycles(1);
      wait_drained("wrap");
      check("wrap_pkt", 64'(pkt_cnt), 64'd8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
